rv32v_ex_mem_pipe: RTL and testbench
====================================

Name: rv32v_ex_mem_pipe

Overview:
- Parametrised, elastic execute→memory pipeline stage for the RV32V vector unit; replaces the fixed two-lane execute/memory bundle.
- Carries NUM_LANES lanes of ALU result, store data, write enable and write offset, plus the shared vector control word and the scalar rd writeback.
- Built as a 2-entry skid FIFO with valid/ready on both sides, flush, and vl/vstart tail/prestart lane gating.

Parameters:
- NUM_LANES, 2, number of element lanes per beat (≥1).
- DATA_W, 32, lane data width.
- OFF_W, 4, per-lane write-offset width (`offset_t` width).

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- flush  in  1  discard all buffered beats
- in_valid  in  1  execute beat valid
- in_ready  out  1  stage can accept
- in_aluresult  in  NUM_LANES*DATA_W  per-lane ALU result, lane i at [i*DATA_W +: DATA_W]
- in_storedata  in  NUM_LANES*DATA_W  per-lane store data
- in_wen  in  NUM_LANES  per-lane write enable
- in_woffset  in  NUM_LANES*OFF_W  per-lane write offset
- in_elem_base  in  32  element index of lane 0
- in_ctrl  in  $bits(vexmem_ctrl_t)  packed control word
- in_rd_sel / in_rd_data / in_rd_wen  in  5/32/1  scalar writeback
- out_valid  out  1  memory beat valid
- out_ready  in  1  memory accepts
- out_aluresult, out_storedata, out_wen, out_woffset, out_ctrl, out_rd_sel, out_rd_data, out_rd_wen  out  widths as inputs

Behaviour:
- Clocking and reset:
  - Single clock CLK.
  - nRST is asynchronous and active-low.
  - Reset sets count=0, all out_* data/ctrl to 0, out_valid=0.
  - in_ready = (count != 2), so it reads 1 in reset; pushes while nRST is low are ignored.
- Push and pop:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready is a function of registered count only; there is no combinational path from out_ready.
- Latency and throughput:
  - Minimum latency is 1 cycle: a beat pushed at edge N appears on out_* after edge N.
  - Sustained throughput is 1 beat/cycle while out_ready=1.
- FIFO ordering:
  - Strict FIFO order.
  - out_* always presents the head entry; it holds stable while out_valid & !out_ready.
- Count cases:
  - count=0: push only.
  - count=1: push and pop may coincide; count stays 1.
  - count=2: in_ready=0; a pop frees space for the next cycle.
- Flush:
  - count←0 and out_valid←0 at the next edge.
  - A same-cycle push is discarded.
  - flush dominates pop.
- Lane gating (at push):
  - Stored wen_i = in_wen_i & (in_elem_base+i < ctrl.vl) & (in_elem_base+i ≥ ctrl.vstart).
  - Compare unsigned 32-bit; the sum wraps modulo 2^32.
  - Data of gated lanes passes through unchanged.
- Scalar writeback:
  - rd_wen is not gated.
  - ctrl.config_type≠NONE beats (vset*) still carry rd.

Optional Feature:
- Macro: RV32V_EX_MEM_PERF_EN.
- When defined, adds outputs out_stall_cnt[31:0] and out_bubble_cnt[31:0]:
  - out_stall_cnt: +1 per cycle with in_valid & !in_ready.
  - out_bubble_cnt: +1 per cycle with out_ready & !out_valid.
  - Both saturate at 0xFFFFFFFF.
  - Reset to 0 by nRST only; flush does not clear them.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- rv32v_types_pkg gains `vexmem_ctrl_t`, a packed struct with fields:
  - load, store, single_bit_write
  - config_type (cfgsel_t)
  - vtype[7:0], next_vtype_csr[7:0], next_avl_csr[31:0]
  - vl[31:0], vstart[31:0]
  - eew (sew_t)
  - vd[4:0]
- A beat-payload struct and the FIFO depth constant (2) also live there.
- One natural sub-module: rv32v_skid_fifo, a generic 2-entry valid/ready buffer parametrised by payload width.
- Gating logic stays in the top module.

Test Plan:
- Single beat, count 0:
  - Stimulus: in_valid=1 for 1 cycle, out_ready=1.
  - Response: out_valid=1 exactly 1 cycle later with identical payload; in_ready stays 1.
- Back-pressure:
  - Stimulus: out_ready=0, push beats A, B, C on consecutive cycles.
  - Response: in_ready drops to 0 after B; C stalls.
  - Then raise out_ready: A, B, C emerge in order with no loss or duplication.
- Tail gating:
  - Stimulus: NUM_LANES=4, vl=6, vstart=0, elem_base=4, in_wen=4'b1111.
  - Response: out_wen=4'b0011.
- Prestart gating:
  - Stimulus: vstart=5, elem_base=4, vl=8, in_wen=4'b1111.
  - Response: out_wen=4'b1110.
- Flush:
  - Stimulus: count=2, flush=1 with a simultaneous push.
  - Response: next cycle out_valid=0, in_ready=1, no stale beat emitted.
- Reset mid-stream, then perf counters:
  - Stimulus: assert nRST low asynchronously while count=2.
  - Response: out_valid=0 and out_* zero immediately.
  - With RV32V_EX_MEM_PERF_EN: 3 stall cycles → out_stall_cnt=3.

Source files
------------

// File: rtl/rv32v_types_pkg.sv
// Shared RV32V vector-unit types: config selector, element width, and the
// execute->memory control word and lane-independent beat payload.
package rv32v_types_pkg;

    typedef enum logic [1:0] {
        CFG_NONE     = 2'd0,
        CFG_VSETVLI  = 2'd1,
        CFG_VSETIVLI = 2'd2,
        CFG_VSETVL   = 2'd3
    } cfgsel_t;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2,
        SEW64 = 2'd3
    } sew_t;

    typedef struct packed {
        logic        load;
        logic        store;
        logic        single_bit_write;
        cfgsel_t     config_type;
        logic [7:0]  vtype;
        logic [7:0]  next_vtype_csr;
        logic [31:0] next_avl_csr;
        logic [31:0] vl;
        logic [31:0] vstart;
        sew_t        eew;
        logic [4:0]  vd;
    } vexmem_ctrl_t;

    // Lane-count-independent part of a beat; per-lane fields are packed around it.
    typedef struct packed {
        vexmem_ctrl_t ctrl;
        logic [4:0]   rd_sel;
        logic [31:0]  rd_data;
        logic         rd_wen;
    } vexmem_beat_t;

    localparam int VEXMEM_DEPTH = 2;

endpackage

// File: rtl/rv32v_skid_fifo.sv
// Generic 2-entry valid/ready skid buffer. in_ready depends only on the
// registered count, so there is no combinational path from out_ready.
module rv32v_skid_fifo
    import rv32v_types_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem_q [VEXMEM_DEPTH];
    logic         wr_ptr_q, rd_ptr_q;
    logic         wr_ptr_d, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push, pop;

    assign in_ready  = (count_q != 2'(VEXMEM_DEPTH));
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = mem_q[rd_ptr_q];

    // Flush overrides both push and pop.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int e = 0; e < VEXMEM_DEPTH; e++) mem_q[e] <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push && !flush) mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: rtl/rv32v_ex_mem_pipe.sv
// Elastic execute->memory stage: vl/vstart lane gating at push into a 2-entry
// skid FIFO. Define RV32V_EX_MEM_PERF_EN to add stall/bubble counters.
module rv32v_ex_mem_pipe
    import rv32v_types_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int DATA_W    = 32,
    parameter int OFF_W     = 4
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_LANES*DATA_W-1:0] in_aluresult,
    input  logic [NUM_LANES*DATA_W-1:0] in_storedata,
    input  logic [NUM_LANES-1:0]        in_wen,
    input  logic [NUM_LANES*OFF_W-1:0]  in_woffset,
    input  logic [31:0]                 in_elem_base,
    input  vexmem_ctrl_t                in_ctrl,
    input  logic [4:0]                  in_rd_sel,
    input  logic [31:0]                 in_rd_data,
    input  logic                        in_rd_wen,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_LANES*DATA_W-1:0] out_aluresult,
    output logic [NUM_LANES*DATA_W-1:0] out_storedata,
    output logic [NUM_LANES-1:0]        out_wen,
    output logic [NUM_LANES*OFF_W-1:0]  out_woffset,
    output vexmem_ctrl_t                out_ctrl,
    output logic [4:0]                  out_rd_sel,
    output logic [31:0]                 out_rd_data,
    output logic                        out_rd_wen
`ifdef RV32V_EX_MEM_PERF_EN
    ,
    output logic [31:0]                 out_stall_cnt,
    output logic [31:0]                 out_bubble_cnt
`endif
);

    localparam int LANE_W = NUM_LANES * (2*DATA_W + OFF_W + 1);
    localparam int PW     = LANE_W + $bits(vexmem_beat_t);

    logic [NUM_LANES-1:0] wen_gated;
    vexmem_beat_t         in_beat, out_beat;
    logic [PW-1:0]        in_payload, out_payload;

    // Element index wraps mod 2^32; gated lanes keep their data, only wen drops.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [31:0] idx;
        assign idx          = in_elem_base + 32'(i);
        assign wen_gated[i] = in_wen[i] & (idx < in_ctrl.vl) & (idx >= in_ctrl.vstart);
    end

    assign in_beat = '{ctrl: in_ctrl, rd_sel: in_rd_sel, rd_data: in_rd_data, rd_wen: in_rd_wen};
    assign in_payload = {in_aluresult, in_storedata, wen_gated, in_woffset, in_beat};
    assign {out_aluresult, out_storedata, out_wen, out_woffset, out_beat} = out_payload;
    assign out_ctrl    = out_beat.ctrl;
    assign out_rd_sel  = out_beat.rd_sel;
    assign out_rd_data = out_beat.rd_data;
    assign out_rd_wen  = out_beat.rd_wen;

    rv32v_skid_fifo #(.W(PW)) u_fifo (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

`ifdef RV32V_EX_MEM_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating; only nRST clears them, flush does not.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (in_valid && !in_ready && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (out_ready && !out_valid && bubble_cnt_q != 32'hFFFF_FFFF)
            bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign out_stall_cnt  = stall_cnt_q;
    assign out_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_rv32v_ex_mem_pipe.sv
// Scoreboard bench for rv32v_ex_mem_pipe: pushes expected beats from a
// reference gating model, a negedge monitor pops and compares.
module tb_rv32v_ex_mem_pipe;
    import rv32v_types_pkg::*;

    localparam int NL = 4;
    localparam int DW = 32;
    localparam int OW = 4;

    logic                 CLK = 1'b0;
    logic                 nRST, flush, in_valid, in_ready, out_valid, out_ready;
    logic [NL*DW-1:0]     in_aluresult, in_storedata, out_aluresult, out_storedata;
    logic [NL-1:0]        in_wen, out_wen;
    logic [NL*OW-1:0]     in_woffset, out_woffset;
    logic [31:0]          in_elem_base, in_rd_data, out_rd_data;
    vexmem_ctrl_t         in_ctrl, out_ctrl;
    logic [4:0]           in_rd_sel, out_rd_sel;
    logic                 in_rd_wen, out_rd_wen;
`ifdef RV32V_EX_MEM_PERF_EN
    logic [31:0]          out_stall_cnt, out_bubble_cnt;
`endif

    always #5 CLK = ~CLK;

    rv32v_ex_mem_pipe #(.NUM_LANES(NL), .DATA_W(DW), .OFF_W(OW)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aluresult(in_aluresult), .in_storedata(in_storedata),
        .in_wen(in_wen), .in_woffset(in_woffset), .in_elem_base(in_elem_base),
        .in_ctrl(in_ctrl), .in_rd_sel(in_rd_sel), .in_rd_data(in_rd_data), .in_rd_wen(in_rd_wen),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_aluresult(out_aluresult), .out_storedata(out_storedata),
        .out_wen(out_wen), .out_woffset(out_woffset), .out_ctrl(out_ctrl),
        .out_rd_sel(out_rd_sel), .out_rd_data(out_rd_data), .out_rd_wen(out_rd_wen)
`ifdef RV32V_EX_MEM_PERF_EN
        , .out_stall_cnt(out_stall_cnt), .out_bubble_cnt(out_bubble_cnt)
`endif
    );

    typedef struct {
        logic [NL*DW-1:0] alu, sd;
        logic [NL-1:0]    wen;
        logic [NL*OW-1:0] woff;
        vexmem_ctrl_t     ctrl;
        logic [4:0]       rd_sel;
        logic [31:0]      rd_data;
        logic             rd_wen;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: lane i is element in_elem_base+i; it writes only inside [vstart, vl).
    function automatic exp_t model();
        exp_t e;
        longint unsigned el;
        e.alu = in_aluresult; e.sd = in_storedata; e.woff = in_woffset;
        e.ctrl = in_ctrl; e.rd_sel = in_rd_sel; e.rd_data = in_rd_data; e.rd_wen = in_rd_wen;
        for (int i = 0; i < NL; i++) begin
            el = (longint'(in_elem_base) + longint'(i)) % 64'h1_0000_0000;
            e.wen[i] = in_wen[i] && (el < longint'(in_ctrl.vl)) && (el >= longint'(in_ctrl.vstart));
        end
        return e;
    endfunction

    always @(negedge CLK) begin
        if (!nRST) begin
            chk("rst_out_valid", 128'(out_valid), 128'(0));
            chk("rst_in_ready", 128'(in_ready), 128'(1));
            chk("rst_out_alu", 128'(out_aluresult), 128'(0));
            chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
            chk("rst_out_wen", 128'(out_wen), 128'(0));
        end else begin
            chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
            chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
            if (out_valid && q.size() != 0) begin
                chk("out_alu", 128'(out_aluresult), 128'(q[0].alu));
                chk("out_sd", 128'(out_storedata), 128'(q[0].sd));
                chk("out_wen", 128'(out_wen), 128'(q[0].wen));
                chk("out_woff", 128'(out_woffset), 128'(q[0].woff));
                chk("out_ctrl", 128'(out_ctrl), 128'(q[0].ctrl));
                chk("out_rd", 128'({out_rd_sel, out_rd_data, out_rd_wen}),
                    128'({q[0].rd_sel, q[0].rd_data, q[0].rd_wen}));
            end
            if (flush) q.delete();
            else begin
                if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
                if (in_valid && in_ready) q.push_back(model());
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic set_beat(input logic [31:0] base, input logic [31:0] vl,
                            input logic [31:0] vstart, input logic [NL-1:0] wen);
        vexmem_ctrl_t c;
        c = '0;
        c.load = 1'($urandom); c.store = 1'($urandom); c.single_bit_write = 1'($urandom);
        c.config_type = cfgsel_t'($urandom_range(0, 3));
        c.vtype = 8'($urandom); c.next_vtype_csr = 8'($urandom); c.next_avl_csr = $urandom;
        c.vl = vl; c.vstart = vstart;
        c.eew = sew_t'($urandom_range(0, 3)); c.vd = 5'($urandom);
        in_ctrl = c;
        in_aluresult = {$urandom, $urandom, $urandom, $urandom};
        in_storedata = {$urandom, $urandom, $urandom, $urandom};
        in_woffset = 16'($urandom);
        in_wen = wen; in_elem_base = base;
        in_rd_sel = 5'($urandom); in_rd_data = $urandom; in_rd_wen = 1'($urandom);
    endtask

    task automatic rand_beat();
        if ($urandom_range(0, 7) == 0)
            set_beat(32'hFFFF_FFFE, 32'($urandom_range(0, 3)), 32'($urandom_range(0, 1)), 4'($urandom));
        else
            set_beat(32'($urandom_range(0, 12)), 32'($urandom_range(0, 16)),
                     32'($urandom_range(0, 16)), 4'($urandom));
    endtask

    initial begin
        bit done;
        nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_beat(0, 0, 0, '0);
        repeat (3) step();
        nRST = 1'b1;
        step();

        // Single beat: visible right after the push edge.
        set_beat(1, 8, 0, 4'hF); in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lat1_valid", 128'(out_valid), 128'(1));
        chk("lat1_ready", 128'(in_ready), 128'(1));
        step();

        // Back-pressure: A, B fill, C stalls until a pop frees a slot.
        out_ready = 1'b0;
        rand_beat(); in_valid = 1'b1; step();
        rand_beat(); step();
        chk("bp_full", 128'(in_ready), 128'(0));
        rand_beat(); step(); step();
        chk("bp_stall", 128'(in_ready), 128'(0));
        out_ready = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            if (in_ready) done = 1'b1;
            step();
        end
        chk("bp_c_accepted", 128'(done), 128'(1));
        in_valid = 1'b0;
        repeat (4) step();

        // Tail and prestart gating.
        set_beat(4, 6, 0, 4'hF); in_valid = 1'b1; step(); in_valid = 1'b0;
        chk("tail_wen", 128'(out_wen), 128'(4'b0011));
        step();
        set_beat(4, 8, 5, 4'hF); in_valid = 1'b1; step(); in_valid = 1'b0;
        chk("prestart_wen", 128'(out_wen), 128'(4'b1110));
        step();

        // Flush from full with a simultaneous push attempt.
        out_ready = 1'b0;
        rand_beat(); in_valid = 1'b1; step();
        rand_beat(); step();
        rand_beat(); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush2_valid", 128'(out_valid), 128'(0));
        chk("flush2_ready", 128'(in_ready), 128'(1));
        // Flush at count 1 discards the same-cycle push.
        rand_beat(); in_valid = 1'b1; step();
        rand_beat(); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush1_valid", 128'(out_valid), 128'(0));
        out_ready = 1'b1;
        repeat (3) step();

        // Asynchronous reset while full; pushes during reset are ignored.
        out_ready = 1'b0;
        rand_beat(); in_valid = 1'b1; step();
        rand_beat(); step();
        #1 nRST = 1'b0;
        q.delete();
        #1;
        chk("arst_valid", 128'(out_valid), 128'(0));
        chk("arst_alu", 128'(out_aluresult), 128'(0));
        chk("arst_sd", 128'(out_storedata), 128'(0));
        chk("arst_rd", 128'({out_rd_sel, out_rd_data, out_rd_wen}), 128'(0));
        step(); step();
        in_valid = 1'b0;
        nRST = 1'b1;
`ifdef RV32V_EX_MEM_PERF_EN
        chk("perf_rst_stall", 128'(out_stall_cnt), 128'(0));
        rand_beat(); in_valid = 1'b1;
        repeat (5) step();
        in_valid = 1'b0;
        chk("perf_stall", 128'(out_stall_cnt), 128'(3));
        chk("perf_bubble", 128'(out_bubble_cnt), 128'(0));
        out_ready = 1'b1;
        repeat (4) step();
`endif

        // Random traffic with occasional flushes.
        for (int n = 0; n < 400; n++) begin
            rand_beat();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) step();
        chk("drain_empty", 128'(q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
